// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set-2 scan-code decoder: resolves E0/F0 prefixes, tracks the two
// shift keys, maps make codes to ASCII and queues key events in a FWFT FIFO.
//
// Ports:
//   clk, rst (sync, active-high)
//   byte_in[7:0], byte_valid    : scan-code bytes from the PS/2 receiver
//   evt_valid, evt_code[7:0], evt_break, evt_ext, evt_ascii[7:0] : FIFO head
//   evt_rd                      : pop the head entry
//   shift_held                  : left or right shift currently held
//   overflow                    : sticky, an event was dropped on a full FIFO
// Parameter FIFO_DEPTH: event FIFO entries, power of two, 2..16.
// Macro SCANCODE_ASCII_EN: builds the ASCII lookup; otherwise evt_ascii = 0.

module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       evt_valid,
  output logic [7:0] evt_code,
  output logic       evt_break,
  output logic       evt_ext,
  output logic [7:0] evt_ascii,
  input  logic       evt_rd,
  output logic       shift_held,
  output logic       overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t      r_state;
  logic        r_lshift;
  logic        r_rshift;

  logic        w_idle;
  logic        w_in_ext;
  logic        w_in_brk;
  logic        w_ignore;
  logic        w_to_ext;
  logic        w_to_brk;
  logic        w_to_extbrk;
  logic        w_fake;
  logic        w_emit;
  logic [7:0]  w_ascii;

  assign w_idle   = (r_state == S_IDLE);
  assign w_in_ext = (r_state == S_EXT) || (r_state == S_EXT_BRK);
  assign w_in_brk = (r_state == S_BRK) || (r_state == S_EXT_BRK);

  // Protocol chatter (ACK, BAT, echo, ...) only outside a prefix sequence.
  always_comb begin
    w_ignore = 1'b0;
    if (w_idle) begin
      case (byte_in)
        8'h00, 8'hAA, 8'hE1, 8'hEE,
        8'hFA, 8'hFE, 8'hFF: w_ignore = 1'b1;
        default:             w_ignore = 1'b0;
      endcase
    end
  end

  assign w_to_ext    = w_idle && (byte_in == 8'hE0);
  assign w_to_brk    = w_idle && (byte_in == 8'hF0);
  assign w_to_extbrk = (r_state == S_EXT) && (byte_in == 8'hF0);
  // E0 12 is the fake shift some keyboards wrap around nav keys.
  assign w_fake      = w_in_ext && (byte_in == 8'h12);

  assign w_emit = byte_valid && !w_ignore && !w_to_ext &&
                  !w_to_brk && !w_to_extbrk && !w_fake;

`ifdef SCANCODE_ASCII_EN
  function automatic logic [7:0] f_ascii(
    input logic [7:0] c,
    input logic       sh
  );
    logic [7:0] lc;
    logic       is_let;
    lc     = 8'h00;
    is_let = 1'b1;
    case (c)
      8'h1C: lc = 8'h61;
      8'h32: lc = 8'h62;
      8'h21: lc = 8'h63;
      8'h23: lc = 8'h64;
      8'h24: lc = 8'h65;
      8'h2B: lc = 8'h66;
      8'h34: lc = 8'h67;
      8'h33: lc = 8'h68;
      8'h43: lc = 8'h69;
      8'h3B: lc = 8'h6A;
      8'h42: lc = 8'h6B;
      8'h4B: lc = 8'h6C;
      8'h3A: lc = 8'h6D;
      8'h31: lc = 8'h6E;
      8'h44: lc = 8'h6F;
      8'h4D: lc = 8'h70;
      8'h15: lc = 8'h71;
      8'h2D: lc = 8'h72;
      8'h1B: lc = 8'h73;
      8'h2C: lc = 8'h74;
      8'h3C: lc = 8'h75;
      8'h2A: lc = 8'h76;
      8'h1D: lc = 8'h77;
      8'h22: lc = 8'h78;
      8'h35: lc = 8'h79;
      8'h1A: lc = 8'h7A;
      default: begin
        is_let = 1'b0;
        case (c)
          8'h45:   lc = 8'h30;
          8'h16:   lc = 8'h31;
          8'h1E:   lc = 8'h32;
          8'h26:   lc = 8'h33;
          8'h25:   lc = 8'h34;
          8'h2E:   lc = 8'h35;
          8'h36:   lc = 8'h36;
          8'h3D:   lc = 8'h37;
          8'h3E:   lc = 8'h38;
          8'h46:   lc = 8'h39;
          8'h29:   lc = 8'h20;
          8'h5A:   lc = 8'h0D;
          8'h66:   lc = 8'h08;
          default: lc = 8'h00;
        endcase
      end
    endcase
    return (is_let && sh) ? (lc - 8'h20) : lc;
  endfunction

  // Shift state before this byte; only plain make codes are mapped.
  assign w_ascii = (!w_in_ext && !w_in_brk) ?
                   f_ascii(byte_in, r_lshift | r_rshift) : 8'h00;
`else
  assign w_ascii = 8'h00;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_lshift <= 1'b0;
      r_rshift <= 1'b0;
    end else if (byte_valid && !w_ignore) begin
      if (w_to_ext) begin
        r_state <= S_EXT;
      end else if (w_to_brk) begin
        r_state <= S_BRK;
      end else if (w_to_extbrk) begin
        r_state <= S_EXT_BRK;
      end else begin
        r_state <= S_IDLE;
        if (!w_in_ext && byte_in == 8'h12) r_lshift <= !w_in_brk;
        if (!w_in_ext && byte_in == 8'h59) r_rshift <= !w_in_brk;
      end
    end
  end

  assign shift_held = r_lshift | r_rshift;

  // Entry layout: {code[17:10], break[9], ext[8], ascii[7:0]}
  logic [17:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [CW-1:0] r_count;
  logic          r_ovf;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic [17:0]   w_head;

  assign w_full = (r_count == CW'(FIFO_DEPTH));
  assign w_pop  = evt_rd && (r_count != '0);
  // A pop on a full FIFO frees the slot the new event lands in.
  assign w_push = w_emit && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {byte_in, w_in_brk, w_in_ext, w_ascii};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_push) r_wr <= r_wr + AW'(1);
      if (w_pop)  r_rd <= r_rd + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_emit && !w_push) r_ovf <= 1'b1;
    end
  end

  // Head fields are gated so stale storage never shows after reset.
  assign w_head    = r_mem[r_rd];
  assign evt_valid = (r_count != '0);
  assign evt_code  = evt_valid ? w_head[17:10] : 8'h00;
  assign evt_break = evt_valid & w_head[9];
  assign evt_ext   = evt_valid & w_head[8];
  assign evt_ascii = evt_valid ? w_head[7:0] : 8'h00;
  assign overflow  = r_ovf;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Self-checking bench for ps2_scancode_decoder: vector table for the
// decode path, hand sequences for FIFO full/empty and reset corners.

module tb_ps2_scancode_decoder;

  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] byte_in = 8'h00;
  logic       byte_valid = 1'b0;
  logic       evt_valid;
  logic [7:0] evt_code;
  logic       evt_break;
  logic       evt_ext;
  logic [7:0] evt_ascii;
  logic       evt_rd = 1'b0;
  logic       shift_held;
  logic       overflow;

  int checks = 0;
  int errors = 0;

  ps2_scancode_decoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .evt_valid  (evt_valid),
    .evt_code   (evt_code),
    .evt_break  (evt_break),
    .evt_ext    (evt_ext),
    .evt_ascii  (evt_ascii),
    .evt_rd     (evt_rd),
    .shift_held (shift_held),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] b;
    logic       ev;
    logic [7:0] code;
    logic       brk;
    logic       ext;
    logic [7:0] asc;
    logic       sh;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [7:0] ea(input logic [7:0] a);
`ifdef SCANCODE_ASCII_EN
    return a;
`else
    return 8'h00 & a;
`endif
  endfunction

  function automatic vec_t mk(
    input logic [7:0] b, input logic ev, input logic [7:0] code,
    input logic brk, input logic ext, input logic [7:0] asc,
    input logic sh
  );
    vec_t v;
    v.b = b; v.ev = ev; v.code = code; v.brk = brk;
    v.ext = ext; v.asc = asc; v.sh = sh;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_in = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic pop();
    @(negedge clk);
    evt_rd = 1'b1;
    @(negedge clk);
    evt_rd = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".valid"}, 32'(evt_valid), 0);
    chk({nm, ".code"}, 32'(evt_code), 0);
    chk({nm, ".brk"}, 32'(evt_break), 0);
    chk({nm, ".ext"}, 32'(evt_ext), 0);
    chk({nm, ".ascii"}, 32'(evt_ascii), 0);
    chk({nm, ".shift"}, 32'(shift_held), 0);
    chk({nm, ".ovf"}, 32'(overflow), 0);
  endtask

  logic [7:0] fill[5];

  initial begin
    fill[0] = 8'h1C; fill[1] = 8'h32; fill[2] = 8'h21;
    fill[3] = 8'h23; fill[4] = 8'h24;

    vecs.push_back(mk(8'h15, 1, 8'h15, 0, 0, ea(8'h71), 0));
    vecs.push_back(mk(8'h12, 1, 8'h12, 0, 0, 8'h00, 1));
    vecs.push_back(mk(8'h15, 1, 8'h15, 0, 0, ea(8'h51), 1));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1));
    vecs.push_back(mk(8'h15, 1, 8'h15, 1, 0, 8'h00, 1));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1));
    vecs.push_back(mk(8'h12, 1, 8'h12, 1, 0, 8'h00, 0));
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h75, 1, 8'h75, 0, 1, 8'h00, 0));
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h75, 1, 8'h75, 1, 1, 8'h00, 0));
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h12, 0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'hAA, 0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h59, 1, 8'h59, 0, 0, 8'h00, 1));
    vecs.push_back(mk(8'h45, 1, 8'h45, 0, 0, ea(8'h30), 1));
    vecs.push_back(mk(8'h1C, 1, 8'h1C, 0, 0, ea(8'h41), 1));
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 8'h00, 1));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1));
    vecs.push_back(mk(8'h12, 0, 8'h00, 0, 0, 8'h00, 1));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 1));
    vecs.push_back(mk(8'h59, 1, 8'h59, 1, 0, 8'h00, 0));
    vecs.push_back(mk(8'h29, 1, 8'h29, 0, 0, ea(8'h20), 0));
    vecs.push_back(mk(8'h5A, 1, 8'h5A, 0, 0, ea(8'h0D), 0));
    vecs.push_back(mk(8'h66, 1, 8'h66, 0, 0, ea(8'h08), 0));
    vecs.push_back(mk(8'h1A, 1, 8'h1A, 0, 0, ea(8'h7A), 0));
    vecs.push_back(mk(8'h16, 1, 8'h16, 0, 0, ea(8'h31), 0));
    vecs.push_back(mk(8'hE0, 0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h5A, 1, 8'h5A, 0, 1, 8'h00, 0));
    vecs.push_back(mk(8'hF0, 0, 8'h00, 0, 0, 8'h00, 0));
    vecs.push_back(mk(8'h1C, 1, 8'h1C, 1, 0, 8'h00, 0));

    do_reset();
    chk_zero("reset");

    foreach (vecs[i]) begin
      send(vecs[i].b);
      chk($sformatf("v%0d.valid", i), 32'(evt_valid), 32'(vecs[i].ev));
      chk($sformatf("v%0d.shift", i), 32'(shift_held), 32'(vecs[i].sh));
      if (vecs[i].ev) begin
        chk($sformatf("v%0d.code", i), 32'(evt_code), 32'(vecs[i].code));
        chk($sformatf("v%0d.brk", i), 32'(evt_break), 32'(vecs[i].brk));
        chk($sformatf("v%0d.ext", i), 32'(evt_ext), 32'(vecs[i].ext));
        chk($sformatf("v%0d.ascii", i), 32'(evt_ascii), 32'(vecs[i].asc));
        pop();
        chk($sformatf("v%0d.popped", i), 32'(evt_valid), 0);
      end
    end

    // Back-to-back bytes past capacity: last one dropped.
    @(negedge clk);
    for (int i = 0; i <= DEPTH; i++) begin
      byte_in = fill[i];
      byte_valid = 1'b1;
      @(negedge clk);
      if (i == DEPTH - 1) chk("full.ovf0", 32'(overflow), 0);
    end
    byte_valid = 1'b0;
    chk("ovf.set", 32'(overflow), 1);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("ovf.code%0d", i), 32'(evt_code), 32'(fill[i]));
      pop();
    end
    chk("ovf.empty", 32'(evt_valid), 0);
    chk("ovf.sticky", 32'(overflow), 1);

    // Full FIFO with simultaneous pop and push.
    do_reset();
    chk("rst.ovf", 32'(overflow), 0);
    @(negedge clk);
    for (int i = 0; i < DEPTH; i++) begin
      byte_in = fill[i];
      byte_valid = 1'b1;
      @(negedge clk);
    end
    byte_in = 8'h2B;
    byte_valid = 1'b1;
    evt_rd = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    evt_rd = 1'b0;
    chk("fullrw.ovf", 32'(overflow), 0);
    for (int i = 1; i <= DEPTH; i++) begin
      chk($sformatf("fullrw.code%0d", i), 32'(evt_code),
          (i == DEPTH) ? 32'h2B : 32'(fill[i]));
      pop();
    end
    chk("fullrw.empty", 32'(evt_valid), 0);

    // Empty FIFO: push with evt_rd keeps the new event.
    @(negedge clk);
    byte_in = 8'h24;
    byte_valid = 1'b1;
    evt_rd = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    evt_rd = 1'b0;
    chk("emptyrw.valid", 32'(evt_valid), 1);
    chk("emptyrw.code", 32'(evt_code), 32'h24);
    pop();
    chk("emptyrw.popped", 32'(evt_valid), 0);

    // Reset in the middle of a break prefix with state held.
    send(8'h12);
    send(8'hF0);
    chk("pre.shift", 32'(shift_held), 1);
    do_reset();
    chk_zero("midrst");
    send(8'h1C);
    chk("post.valid", 32'(evt_valid), 1);
    chk("post.code", 32'(evt_code), 32'h1C);
    chk("post.brk", 32'(evt_break), 0);
    chk("post.ascii", 32'(evt_ascii), 32'(ea(8'h61)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
